// File: rtl/piso_serializer_pkg.sv
// ----------------------------------------------------------------------------
// piso_serializer_pkg
// Shared definitions for the parallel-in/serial-out serializer family:
//   - piso_state_e : 2-bit FSM state encoding (IDLE, SHIFT, GAP)
//   - cnt_width()  : clog2-based counter width, never narrower than one bit
// No ports (package).
// ----------------------------------------------------------------------------
package piso_serializer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } piso_state_e;

    // Width needed to count 0..n-1; a one-value counter still gets one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/piso_bit_timer.sv
// ----------------------------------------------------------------------------
// piso_bit_timer
// Counts the clock cycles of one serial bit period and flags its last cycle.
// Shared between the serializer and the matching deserializer.
// Ports:
//   clk_i  - clock, rising edge
//   rst_ni - asynchronous active-low reset
//   clr_i  - synchronous clear; holds the count at zero
//   en_i   - advance the count this cycle
//   tc_o   - high on the last cycle of a bit period (count == BIT_CYCLES-1)
// ----------------------------------------------------------------------------
module piso_bit_timer
    import piso_serializer_pkg::*;
#(
    parameter int BIT_CYCLES = 1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int               CYC_W    = cnt_width(BIT_CYCLES);
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(BIT_CYCLES - 1);

    logic [CYC_W-1:0] cyc_q;
    logic [CYC_W-1:0] cyc_d;

    // Next count: cleared, wrapped at the terminal count, or incremented.
    always_comb begin
        cyc_d = cyc_q;
        if (clr_i) begin
            cyc_d = '0;
        end else if (en_i) begin
            if (cyc_q == CYC_LAST) begin
                cyc_d = '0;
            end else begin
                cyc_d = cyc_q + CYC_W'(1);
            end
        end else begin
            cyc_d = cyc_q;
        end
    end

    assign tc_o = en_i && !clr_i && (cyc_q == CYC_LAST);

    // Cycle counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cyc_q <= '0;
        end else begin
            cyc_q <= cyc_d;
        end
    end

endmodule

// File: rtl/piso_serializer.sv
// ----------------------------------------------------------------------------
// piso_serializer
// Accepts one WIDTH-bit word per valid/ready handshake and shifts it out
// LSB-first, each bit held BIT_CYCLES clocks, followed by GAP_CYCLES idle
// clocks. Every output is a flop; nothing passes combinationally from an
// input to an output.
// Ports:
//   clk       - clock, rising edge
//   rst       - asynchronous active-low reset
//   in_data   - parallel word, sampled only on the accepting edge
//   in_valid  - in_data is valid
//   in_ready  - a word can be accepted this cycle
//   ser_out   - serial data, LSB first
//   ser_valid - ser_out carries a data bit this cycle
//   word_done - one-cycle pulse after the last bit of a word
//   busy      - FSM is in SHIFT or GAP
// ----------------------------------------------------------------------------
module piso_serializer
    import piso_serializer_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int BIT_CYCLES = 1,
    parameter int GAP_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int               IDX_W      = cnt_width(WIDTH);
    localparam int               GAP_W      = cnt_width(GAP_CYCLES + 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(WIDTH - 1);
    localparam int               GAP_LAST_I = (GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0;
    localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'(GAP_LAST_I);

    piso_state_e      state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [IDX_W-1:0] bit_idx_q;
    logic [GAP_W-1:0] gap_q;
    logic             in_ready_q;
    logic             ser_out_q;
    logic             ser_valid_q;
    logic             word_done_q;
    logic             busy_q;

    logic             bit_tc_s;
    logic             timer_en_s;
    logic             accept_s;

    // The bit timer only runs while shifting and is held at zero otherwise,
    // so every word starts on a fresh bit period.
    assign timer_en_s = (state_q == SHIFT);
    assign accept_s   = (state_q == IDLE) && in_ready_q && in_valid;

    piso_bit_timer #(
        .BIT_CYCLES (BIT_CYCLES)
    ) u_bit_timer (
        .clk_i  (clk),
        .rst_ni (rst),
        .clr_i  (!timer_en_s),
        .en_i   (timer_en_s),
        .tc_o   (bit_tc_s)
    );

    // Main FSM with registered outputs.
    // in_ready stays low on the first cycle after reset release and only
    // rises on the first edge in IDLE, so in_valid held through reset is
    // first honoured on the second edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            bit_idx_q   <= '0;
            gap_q       <= '0;
            in_ready_q  <= 1'b0;
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            word_done_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            word_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept_s) begin
                        shreg_q     <= in_data;
                        bit_idx_q   <= '0;
                        in_ready_q  <= 1'b0;
                        // Bit 0 goes out the very next cycle.
                        ser_out_q   <= in_data[0];
                        ser_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= SHIFT;
                    end else begin
                        in_ready_q  <= 1'b1;
                        ser_out_q   <= 1'b0;
                        ser_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (bit_tc_s) begin
                        shreg_q <= {1'b0, shreg_q[WIDTH-1:1]};
                        if (bit_idx_q == IDX_LAST) begin
                            bit_idx_q   <= '0;
                            ser_out_q   <= 1'b0;
                            ser_valid_q <= 1'b0;
                            word_done_q <= 1'b1;
                            if (GAP_CYCLES > 0) begin
                                gap_q   <= '0;
                                state_q <= GAP;
                            end else begin
                                in_ready_q <= 1'b1;
                                busy_q     <= 1'b0;
                                state_q    <= IDLE;
                            end
                        end else begin
                            bit_idx_q <= bit_idx_q + IDX_W'(1);
                            // Present the bit that becomes shreg[0] after this shift.
                            ser_out_q <= shreg_q[1];
                        end
                    end else begin
                        ser_out_q <= shreg_q[0];
                    end
                end
                GAP: begin
                    // The word_done cycle is the first gap cycle.
                    if (gap_q == GAP_LAST) begin
                        gap_q      <= '0;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= IDLE;
                    end else begin
                        gap_q <= gap_q + GAP_W'(1);
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b0;
                    ser_out_q   <= 1'b0;
                    ser_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign ser_out   = ser_out_q;
    assign ser_valid = ser_valid_q;
    assign word_done = word_done_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_piso_serializer.sv
// ----------------------------------------------------------------------------
// tb_piso_serializer
// Two serializers share one stimulus stream: instance 0 with BIT_CYCLES=1,
// GAP_CYCLES=1 and instance 1 with BIT_CYCLES=3, GAP_CYCLES=0. A timeline
// model (phase = cycles since the accepting edge) predicts every output on
// every cycle; directed sections pin the model with literal expectations.
// ----------------------------------------------------------------------------
module tb_piso_serializer;

    localparam int W     = 4;
    localparam int BC_A  = 1;
    localparam int GAP_A = 1;
    localparam int BC_B  = 3;
    localparam int GAP_B = 0;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic [1:0]   in_ready_s, ser_out_s, ser_valid_s, word_done_s, busy_s;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: p = -2 just out of reset, -1 idle, >=0 cycles since accept.
    int           p_m [2];
    logic [W-1:0] w_m [2];
    logic [W-1:0] sr_m [2];
    int           vcnt_m [2];

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(W), .BIT_CYCLES(BC_A), .GAP_CYCLES(GAP_A)) u_dut_a (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_s[0]), .ser_out(ser_out_s[0]), .ser_valid(ser_valid_s[0]),
        .word_done(word_done_s[0]), .busy(busy_s[0])
    );

    piso_serializer #(.WIDTH(W), .BIT_CYCLES(BC_B), .GAP_CYCLES(GAP_B)) u_dut_b (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_s[1]), .ser_out(ser_out_s[1]), .ser_valid(ser_valid_s[1]),
        .word_done(word_done_s[1]), .busy(busy_s[1])
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int bc_of(input int i);
        return (i == 0) ? BC_A : BC_B;
    endfunction

    function automatic int gap_of(input int i);
        return (i == 0) ? GAP_A : GAP_B;
    endfunction

    function automatic logic exp_ready(input int p, input int bc, input int gap);
        return (p == -1) || (p >= W * bc + gap);
    endfunction

    // Expected {ser_out, ser_valid, word_done, in_ready, busy}.
    function automatic logic [4:0] exp_out(input int p, input logic [W-1:0] w,
                                           input int bc, input int gap);
        logic [4:0] e;
        if (p == -2)                e = 5'b00000;
        else if (p == -1)           e = 5'b00010;
        else if (p < W * bc)        e = {w[p / bc], 1'b1, 1'b0, 1'b0, 1'b1};
        else if (p == W * bc)       e = {1'b0, 1'b0, 1'b1, exp_ready(p, bc, gap), (gap > 0)};
        else if (p < W * bc + gap)  e = 5'b00001;
        else                        e = 5'b00010;
        return e;
    endfunction

    // Reference timeline advance.
    always @(posedge clk or negedge rst) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst) begin
                p_m[i] <= -2;
            end else if (exp_ready(p_m[i], bc_of(i), gap_of(i)) && p_m[i] != -2 && in_valid) begin
                p_m[i] <= 0;
                w_m[i] <= in_data;
            end else if (p_m[i] == -2) begin
                p_m[i] <= -1;
            end else if (p_m[i] >= 0) begin
                p_m[i] <= (p_m[i] >= W * bc_of(i) + gap_of(i)) ? -1 : p_m[i] + 1;
            end
        end
    end

    // Per-cycle compare plus a downstream 4-bit shift register rebuilt from ser_out.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            check((i == 0) ? "outputs_a" : "outputs_b",
                  int'({ser_out_s[i], ser_valid_s[i], word_done_s[i], in_ready_s[i], busy_s[i]}),
                  int'(exp_out(p_m[i], w_m[i], bc_of(i), gap_of(i))));
            if (!rst) begin
                vcnt_m[i] <= 0;
            end else begin
                if (ser_valid_s[i]) begin
                    if (vcnt_m[i] % bc_of(i) == 0) sr_m[i] <= {ser_out_s[i], sr_m[i][W-1:1]};
                    vcnt_m[i] <= vcnt_m[i] + 1;
                end
                if (word_done_s[i]) begin
                    check((i == 0) ? "word_rebuilt_a" : "word_rebuilt_b", int'(sr_m[i]), int'(w_m[i]));
                    check((i == 0) ? "valid_cycles_a" : "valid_cycles_b", vcnt_m[i], W * bc_of(i));
                    vcnt_m[i] <= 0;
                end
            end
        end
    end

    initial begin
        logic [9:0]  t2_ser, t2_val, t2_rdy;
        logic [11:0] t3_ser;
        logic [3:0]  t1_ser;
        int          cnt_v, cnt_d;
        logic        found;

        // Reset with in_valid already high.
        rst = 1'b0; in_valid = 1'b1; in_data = 4'hF;
        repeat (3) @(negedge clk);
        check("rst_ready", int'(in_ready_s[0]), 0);
        check("rst_busy", int'(busy_s[0]), 0);
        check("rst_ser_out", int'(ser_out_s[0]), 0);
        #1 rst = 1'b1;
        @(negedge clk);
        check("ready_after_first_edge", int'(in_ready_s[0]), 1);
        check("no_accept_first_edge", int'(busy_s[0]), 0);
        @(negedge clk);
        check("accept_second_edge", int'(busy_s[0]), 1);
        in_valid = 1'b0;
        repeat (20) @(negedge clk);

        // Single word 4'b1011.
        t1_ser = 4'b1011;
        in_data = t1_ser; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("t1_ser", int'(ser_out_s[0]), int'(t1_ser[k]));
            check("t1_valid", int'(ser_valid_s[0]), 1);
            @(negedge clk);
        end
        check("t1_done", int'(word_done_s[0]), 1);
        @(negedge clk);
        check("t1_ready", int'(in_ready_s[0]), 1);

        // in_valid held: 4'hA then 4'h5.
        t2_ser = 10'b0101001010;
        t2_val = 10'b1111001111;
        t2_rdy = 10'b0000100000;
        in_data = 4'hA; in_valid = 1'b1;
        @(negedge clk);
        in_data = 4'h5;
        for (int k = 0; k < 10; k++) begin
            check("t2_ser", int'(ser_out_s[0]), int'(t2_ser[k]));
            check("t2_valid", int'(ser_valid_s[0]), int'(t2_val[k]));
            check("t2_ready", int'(in_ready_s[0]), int'(t2_rdy[k]));
            if (k == 6) in_valid = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (20) @(negedge clk);

        // BIT_CYCLES=3 instance, 4'b0110.
        t3_ser = 12'b000111111000;
        in_data = 4'b0110; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 12; k++) begin
            check("t3_ser", int'(ser_out_s[1]), int'(t3_ser[k]));
            check("t3_valid", int'(ser_valid_s[1]), 1);
            @(negedge clk);
        end
        check("t3_valid_end", int'(ser_valid_s[1]), 0);
        check("t3_done", int'(word_done_s[1]), 1);
        repeat (20) @(negedge clk);

        // Reset during bit 1 of 4'hF.
        in_data = 4'hF; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        check("t4_ser_out", int'(ser_out_s[0]), 0);
        check("t4_ser_valid", int'(ser_valid_s[0]), 0);
        check("t4_busy", int'(busy_s[0]), 0);
        check("t4_ready", int'(in_ready_s[0]), 0);
        check("t4_busy_b", int'(busy_s[1]), 0);
        @(negedge clk);
        check("t4_no_done", int'(word_done_s[0]), 0);
        @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("t4_ready_after", int'(in_ready_s[0]), 1);

        // Word 4'b1001 reassembled downstream.
        in_data = 4'b1001; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (word_done_s[0]) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("t5_done_seen", int'(found), 1);
        #1;
        check("t5_shreg", int'(sr_m[0]), 9);
        check("t5_q_bit0", int'(sr_m[0][0]), 1);
        repeat (20) @(negedge clk);

        // in_valid pulse while busy is ignored.
        in_data = 4'hC; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        in_data = 4'h3; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        cnt_v = 0; cnt_d = 0;
        for (int k = 0; k < 20; k++) begin
            if (ser_valid_s[0]) cnt_v++;
            if (word_done_s[0]) cnt_d++;
            @(negedge clk);
        end
        check("t6_valid_cycles", cnt_v, 2);
        check("t6_done_count", cnt_d, 1);

        // Randomized traffic with occasional resets.
        for (int k = 0; k < 800; k++) begin
            #1;
            in_valid = ($urandom_range(0, 2) != 0);
            in_data  = W'($urandom);
            rst      = ($urandom_range(0, 199) != 0);
            @(negedge clk);
        end
        #1 rst = 1'b1; in_valid = 1'b0;
        repeat (20) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
